dequantize: RTL and testbench
=============================

Name: dequantize

Overview:
- Reads INT4 vectors back out of the quantized-output RAM written by the quantizer and rescales each lane by its per-lane scale factor.
- Emits full-width signed vectors, 16 lanes × 40 bit, toward the next layer's datapath.
- Sits between the quantized-output RAM (read port) and the downstream consumer; supports valid/ready backpressure.
- One `i_start` runs one pass over all `DEPTH` RAM rows.

Parameters:
- `LANES`, 16, number of lanes per RAM row
- `Q_W`, 4, width of each quantized lane (signed two's complement)
- `SF_W`, 8, width of each per-lane scale factor (unsigned)
- `DATA_W`, 40, width of each dequantized output lane (signed)
- `DEPTH`, 64, RAM rows per pass
- `ADDR_W`, 6, RAM address width, equal to log2(`DEPTH`)
- `OUT_SHIFT`, 0, left shift applied to each product before output

Ports:
- `i_clk`  in  1  clock; single clock domain
- `i_rst`  in  1  asynchronous, active-high reset
- `i_start`  in  1  start-pass pulse; sampled only in IDLE
- `i_sf`  in  LANES*SF_W  per-lane scale factors; lane g at [g*SF_W +: SF_W]; latched when start is accepted
- `o_busy`  out  1  high while state != IDLE
- `o_done`  out  1  one-cycle pulse after the final row is popped
- `o_ram_re`  out  1  RAM read enable
- `o_ram_addr`  out  ADDR_W  RAM read address
- `i_ram_data`  in  LANES*Q_W  RAM read data; valid exactly one cycle after `o_ram_re`
- `o_valid`  out  1  output row valid
- `o_data`  out  LANES*DATA_W  dequantized row; lane g at [g*DATA_W +: DATA_W]
- `o_addr`  out  ADDR_W  row index of `o_data`
- `i_ready`  in  1  consumer ready; pop = `o_valid` & `i_ready`

Behaviour:
- Clock and reset are fixed: one clock `i_clk`; `i_rst` is asynchronous and active-high.
- Reset values:
  - state = IDLE
  - all outputs 0
  - read address counter, in-flight flag, queue count/pointers, latched scale factors and output row counter all 0
- States: IDLE, RUN, DRAIN.
- IDLE:
  - On `i_start`=1: latch `i_sf` into the scale factor registers, clear counters, go to RUN.
  - `i_start` in RUN or DRAIN is ignored, with no effect on latched scale factors.
- RUN:
  - `o_ram_re` and `o_ram_addr` are combinational from registered state.
  - `o_ram_re`=1 when credit allows: (queue count + in-flight − pop) < 2.
  - On each issued read, the read address increments at the clock edge.
  - After issuing address `DEPTH`−1, go to DRAIN; no further reads are issued.
- DRAIN: when the queue is empty, no read is in flight and the last row has been popped, go to IDLE.
- `o_done`: registered one-cycle pulse, high in the cycle after the pop of row `DEPTH`−1.
- Read pipeline: the in-flight flag is set on issue. In the next cycle `i_ram_data` is valid and the computed row is pushed into the output queue at that cycle's closing edge.
- Output queue: 2-entry FIFO with registered head.
  - `o_valid` = queue not empty.
  - `o_data` and `o_addr` are held stable while `o_valid`=1 and `i_ready`=0.
  - Push and pop in the same cycle are legal; count is unchanged.
  - Overflow is impossible by the credit rule; a push into a full queue is a design error.
- Arithmetic, per lane g:
  - q = signed `i_ram_data`[g*4 +: 4], range −8..7.
  - s = unsigned latched sf[g], range 0..255.
  - p = q × s as a signed 12-bit value (s zero-extended to 9 bits before the signed multiply).
  - Output = sign-extend(p) to `DATA_W`, then << `OUT_SHIFT`, truncated to `DATA_W`.
- Latency and throughput:
  - Start accepted at edge E0 → first `o_ram_re` in the cycle after E0 → first `o_valid` after edge E2.
  - With `i_ready` held 1: one row per cycle, rows 0..63 in order, `o_addr` = row index.
- `o_addr` wraps naturally; a pass is always exactly `DEPTH` rows.
- Reset mid-pass: immediately returns to the reset state and abandons all in-flight and queued data. The next pass requires a new `i_start`.

Test Plan:
- Reset check: assert `i_rst` mid-cycle → `o_busy`, `o_valid`, `o_ram_re`, `o_done` go to 0 asynchronously; `o_ram_addr`=0.
- Basic pass:
  - Stimulus: sf all lanes = 2; RAM row r holds every lane = r[3:0] interpreted signed; `i_ready`=1.
  - Response: row 3 → every lane = 6; row 9 (q=−7) → every lane = 40'hFFFFFFFFF2.
  - Timing: 64 contiguous valid cycles with `o_addr` 0..63; `o_done` one cycle after row 63; `o_busy` falls.
- Extremes:
  - Lane 0: q=−8, sf=255 → 40'hFFFFFFF808.
  - Lane 1: q=7, sf=255 → 40'h00000006F9.
  - Lane 2: sf=0 → 0.
- Backpressure:
  - `i_ready` low for rows 5..9 → `o_data`/`o_addr` frozen at row 5.
  - `o_ram_re` stalls after 2 rows are outstanding.
  - After release, rows 5..63 arrive in order with no loss or duplication.
- Start while busy: pulse `i_start` with different `i_sf` at row 20 → ignored; remaining outputs use the original scale factors; exactly 64 rows total.
- Reset mid-pass: assert `i_rst` at row 30, then issue a new start → the new pass begins at row 0 with the newly latched sf; no stale rows are emitted.

Source files
------------

// File: rtl/dequantize.sv
// dequantize: reads INT4 rows from the quantized-output RAM, multiplies every
// lane by its latched per-lane scale factor and streams full-width signed rows
// to the consumer through a 2-entry output queue with valid/ready handshake.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for i_start; scale factors latched on accept
// RUN   | issuing RAM reads as queue credit allows, rows 0..DEPTH-1
// DRAIN | all reads issued; waiting for the queue and read pipe to empty
module dequantize #(
  parameter int LANES     = 16,
  parameter int Q_W       = 4,
  parameter int SF_W      = 8,
  parameter int DATA_W    = 40,
  parameter int DEPTH     = 64,
  parameter int ADDR_W    = 6,
  parameter int OUT_SHIFT = 0
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_start,
  input  logic [LANES*SF_W-1:0]     i_sf,
  output logic                      o_busy,
  output logic                      o_done,
  output logic                      o_ram_re,
  output logic [ADDR_W-1:0]         o_ram_addr,
  input  logic [LANES*Q_W-1:0]      i_ram_data,
  output logic                      o_valid,
  output logic [LANES*DATA_W-1:0]   o_data,
  output logic [ADDR_W-1:0]         o_addr,
  input  logic                      i_ready
);

  localparam int P_W = Q_W + SF_W;
  localparam logic [ADDR_W-1:0] LAST_ROW = ADDR_W'(DEPTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  state_t                    state_q, state_d;
  logic [ADDR_W-1:0]         rd_addr_q, rd_addr_d;
  logic                      infl_q, infl_d;
  logic [ADDR_W-1:0]         infl_addr_q, infl_addr_d;
  logic [LANES*SF_W-1:0]     sf_q, sf_d;
  logic [1:0]                cnt_q, cnt_d;
  logic [LANES*DATA_W-1:0]   head_data_q, head_data_d;
  logic [ADDR_W-1:0]         head_addr_q, head_addr_d;
  logic [LANES*DATA_W-1:0]   tail_data_q, tail_data_d;
  logic [ADDR_W-1:0]         tail_addr_q, tail_addr_d;
  logic [ADDR_W-1:0]         out_row_q, out_row_d;
  logic                      done_q, done_d;

  logic                      pop;
  logic                      push;
  logic [2:0]                credit;
  logic                      last_issue;
  logic [LANES*DATA_W-1:0]   row_new;

  // Per-lane rescale: signed q times zero-extended scale, then sign-extend and shift.
  for (genvar g = 0; g < LANES; g++) begin : g_lane
    logic signed [P_W-1:0] prod;
    logic [Q_W-1:0]        q;
    logic [SF_W-1:0]       s;
    assign q    = i_ram_data[g*Q_W +: Q_W];
    assign s    = sf_q[g*SF_W +: SF_W];
    assign prod = $signed({{SF_W{q[Q_W-1]}}, q}) * $signed({{Q_W{1'b0}}, s});
    assign row_new[g*DATA_W +: DATA_W] = {{(DATA_W-P_W){prod[P_W-1]}}, prod} << OUT_SHIFT;
  end

  // Handshake and read-credit terms; credit keeps at most 2 rows queued or in flight.
  always_comb begin
    pop        = (cnt_q != 2'd0) && i_ready;
    push       = infl_q;
    credit     = {1'b0, cnt_q} + {2'b00, infl_q} - {2'b00, pop};
    last_issue = o_ram_re && (rd_addr_q == LAST_ROW);
  end

  // State register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; once in DRAIN every row has been issued, so an empty
  // queue with nothing in flight means the last row has been popped.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (i_start) state_d = S_RUN;
      S_RUN:   if (last_issue) state_d = S_DRAIN;
      S_DRAIN: if ((cnt_q == 2'd0) && !infl_q) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs, combinational from registered state.
  always_comb begin
    o_busy     = (state_q != S_IDLE);
    o_ram_re   = (state_q == S_RUN) && (credit < 3'd2);
    o_ram_addr = rd_addr_q;
  end

  // Datapath next values: read counter, read pipe, output queue, done pulse.
  always_comb begin
    rd_addr_d   = rd_addr_q;
    infl_d      = 1'b0;
    infl_addr_d = infl_addr_q;
    sf_d        = sf_q;
    cnt_d       = cnt_q;
    head_data_d = head_data_q;
    head_addr_d = head_addr_q;
    tail_data_d = tail_data_q;
    tail_addr_d = tail_addr_q;
    out_row_d   = out_row_q;
    done_d      = 1'b0;
    if ((state_q == S_IDLE) && i_start) begin
      sf_d      = i_sf;
      rd_addr_d = '0;
      out_row_d = '0;
      cnt_d     = 2'd0;
    end else begin
      if (o_ram_re) begin
        rd_addr_d   = rd_addr_q + ADDR_W'(1);
        infl_d      = 1'b1;
        infl_addr_d = rd_addr_q;
      end
      // Credit rule guarantees a push never lands in a full queue.
      case ({push, pop})
        2'b10: begin
          if (cnt_q == 2'd0) begin
            head_data_d = row_new;
            head_addr_d = infl_addr_q;
          end else begin
            tail_data_d = row_new;
            tail_addr_d = infl_addr_q;
          end
          cnt_d = cnt_q + 2'd1;
        end
        2'b01: begin
          head_data_d = tail_data_q;
          head_addr_d = tail_addr_q;
          cnt_d       = cnt_q - 2'd1;
        end
        2'b11: begin
          if (cnt_q == 2'd1) begin
            head_data_d = row_new;
            head_addr_d = infl_addr_q;
          end else begin
            head_data_d = tail_data_q;
            head_addr_d = tail_addr_q;
            tail_data_d = row_new;
            tail_addr_d = infl_addr_q;
          end
        end
        default: ;
      endcase
      if (pop) begin
        out_row_d = out_row_q + ADDR_W'(1);
        done_d    = (out_row_q == LAST_ROW);
      end
    end
  end

  // Datapath registers; reset abandons anything queued or in flight.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rd_addr_q   <= '0;
      infl_q      <= 1'b0;
      infl_addr_q <= '0;
      sf_q        <= '0;
      cnt_q       <= 2'd0;
      head_data_q <= '0;
      head_addr_q <= '0;
      tail_data_q <= '0;
      tail_addr_q <= '0;
      out_row_q   <= '0;
      done_q      <= 1'b0;
    end else begin
      rd_addr_q   <= rd_addr_d;
      infl_q      <= infl_d;
      infl_addr_q <= infl_addr_d;
      sf_q        <= sf_d;
      cnt_q       <= cnt_d;
      head_data_q <= head_data_d;
      head_addr_q <= head_addr_d;
      tail_data_q <= tail_data_d;
      tail_addr_q <= tail_addr_d;
      out_row_q   <= out_row_d;
      done_q      <= done_d;
    end
  end

  // Queue head drives the output port directly.
  always_comb begin
    o_valid = (cnt_q != 2'd0);
    o_data  = head_data_q;
    o_addr  = head_addr_q;
    o_done  = done_q;
  end

endmodule

// File: tb/tb_dequantize.sv
// Bench for dequantize: RAM model, integer-arithmetic reference, pop monitor.
module tb_dequantize;
  localparam int LANES = 16, Q_W = 4, SF_W = 8, DATA_W = 40, DEPTH = 64, ADDR_W = 6;
  localparam int RW = LANES * DATA_W;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    start;
  logic [LANES*SF_W-1:0]   sf_in;
  logic                    busy, done, ram_re;
  logic [ADDR_W-1:0]       ram_addr;
  logic [LANES*Q_W-1:0]    ram_data;
  logic                    valid;
  logic [RW-1:0]           data;
  logic [ADDR_W-1:0]       addr;
  logic                    rdy;

  dequantize dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_sf(sf_in),
    .o_busy(busy), .o_done(done), .o_ram_re(ram_re), .o_ram_addr(ram_addr),
    .i_ram_data(ram_data), .o_valid(valid), .o_data(data), .o_addr(addr),
    .i_ready(rdy)
  );

  always #5 clk = ~clk;

  logic [LANES*Q_W-1:0] ram [DEPTH];
  always @(posedge clk) if (ram_re) ram_data <= ram[ram_addr];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [RW-1:0] act, input logic [RW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Reference: each lane is signed q times unsigned s in plain integer arithmetic.
  function automatic logic [RW-1:0] model_row(input logic [LANES*Q_W-1:0] row,
                                              input logic [LANES*SF_W-1:0] sf);
    logic [RW-1:0] r;
    longint v;
    int q, s;
    r = '0;
    for (int g = 0; g < LANES; g++) begin
      q = int'($signed(row[g*Q_W +: Q_W]));
      s = int'(sf[g*SF_W +: SF_W]);
      v = longint'(q * s);
      r[g*DATA_W +: DATA_W] = v[DATA_W-1:0];
    end
    return r;
  endfunction

  logic                  mon_en = 1'b0;
  int                    pops = 0;
  int                    base = 0;
  int                    mon_idx;
  logic [LANES*SF_W-1:0] sf_exp;
  logic [RW-1:0]         got [DEPTH];

  // Every popped row must be the next row of the pass with the expected values.
  always @(negedge clk) begin
    if (mon_en && !rst && valid && rdy) begin
      mon_idx = pops - base;
      if (mon_idx >= DEPTH) chk("row_count_overrun", RW'(mon_idx), RW'(DEPTH - 1));
      else begin
        chk("row_addr", RW'(addr), RW'(mon_idx));
        chk("row_data", data, model_row(ram[mon_idx], sf_exp));
        got[mon_idx] = data;
      end
      pops++;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic fill_ram(input int mode);
    for (int r = 0; r < DEPTH; r++) begin
      ram[r] = {$urandom, $urandom};
      for (int g = 0; g < LANES; g++) begin
        if (mode == 0) ram[r][g*Q_W +: Q_W] = 4'(r);
        if (mode == 2 && g == 0) ram[r][g*Q_W +: Q_W] = 4'h8;
        if (mode == 2 && g == 1) ram[r][g*Q_W +: Q_W] = 4'h7;
      end
    end
  endtask

  function automatic logic [LANES*SF_W-1:0] rand_sf();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic start_pass(input logic [LANES*SF_W-1:0] sf);
    base   = pops;
    sf_exp = sf;
    sf_in  = sf;
    start  = 1'b1;
    tick();
    start  = 1'b0;
  endtask

  task automatic wait_rows(input int n, input string tag);
    int c = 0;
    while ((pops - base) < n && c < 2000) begin tick(); c++; end
    chk(tag, RW'(c < 2000), RW'(1));
  endtask

  task automatic wait_done(input string tag);
    int c = 0;
    while (!done && c < 3000) begin @(negedge clk); c++; end
    chk({tag, "_done_seen"}, RW'(c < 3000), RW'(1));
    chk({tag, "_rows"}, RW'(pops - base), RW'(DEPTH));
    @(negedge clk);
    chk({tag, "_busy_fall"}, RW'(busy), RW'(0));
    chk({tag, "_done_pulse"}, RW'(done), RW'(0));
  endtask

  initial begin
    logic [LANES*SF_W-1:0] sf;
    int vcnt;
    rst = 1'b1; start = 1'b0; sf_in = '0; rdy = 1'b1;
    repeat (3) tick();
    chk("rst_busy", RW'(busy), RW'(0));
    chk("rst_valid", RW'(valid), RW'(0));
    chk("rst_re", RW'(ram_re), RW'(0));
    chk("rst_done", RW'(done), RW'(0));
    chk("rst_addr", RW'(ram_addr), RW'(0));
    rst = 1'b0;
    tick();
    mon_en = 1'b1;

    // Basic pass: sf=2 everywhere, lane value = row[3:0] as signed.
    fill_ram(0);
    sf = '0;
    for (int g = 0; g < LANES; g++) sf[g*SF_W +: SF_W] = 8'd2;
    start_pass(sf);
    @(negedge clk);
    chk("lat_e0_valid", RW'(valid), RW'(0));
    chk("lat_e0_re", RW'(ram_re), RW'(1));
    chk("lat_e0_addr", RW'(ram_addr), RW'(0));
    @(negedge clk);
    chk("lat_e1_valid", RW'(valid), RW'(0));
    @(negedge clk);
    chk("lat_e2_valid", RW'(valid), RW'(1));
    vcnt = 0;
    while (valid && vcnt < 100) begin vcnt++; @(negedge clk); end
    chk("basic_contig", RW'(vcnt), RW'(DEPTH));
    chk("basic_done", RW'(done), RW'(1));
    @(negedge clk);
    chk("basic_done_pulse", RW'(done), RW'(0));
    chk("basic_busy", RW'(busy), RW'(0));
    chk("basic_row3", RW'(got[3][DATA_W-1:0]), RW'(40'd6));
    chk("basic_row9", RW'(got[9][DATA_W-1:0]), RW'(40'hFFFFFFFFF2));
    chk("basic_row9_l15", RW'(got[9][15*DATA_W +: DATA_W]), RW'(40'hFFFFFFFFF2));

    // Extremes: q=-8/7 with sf=255, and sf=0.
    tick();
    fill_ram(2);
    sf = rand_sf();
    sf[0 +: 8] = 8'd255; sf[8 +: 8] = 8'd255; sf[16 +: 8] = 8'd0;
    start_pass(sf);
    wait_done("ext");
    chk("ext_l0", RW'(got[10][0 +: DATA_W]), RW'(40'hFFFFFFF808));
    chk("ext_l1", RW'(got[10][DATA_W +: DATA_W]), RW'(40'h00000006F9));
    chk("ext_l2", RW'(got[10][2*DATA_W +: DATA_W]), RW'(0));

    // Backpressure: hold ready low while row 5 is at the head.
    tick();
    fill_ram(1);
    start_pass(rand_sf());
    wait_rows(5, "bp_reach5");
    rdy = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("bp_hold_valid", RW'(valid), RW'(1));
      chk("bp_hold_addr", RW'(addr), RW'(5));
      chk("bp_hold_data", data, model_row(ram[5], sf_exp));
      chk("bp_re_stall", RW'(ram_re), RW'(0));
    end
    tick();
    rdy = 1'b1;
    wait_done("bp");

    // Start while busy is ignored; original scale factors stay in effect.
    tick();
    fill_ram(1);
    start_pass(rand_sf());
    wait_rows(20, "sb_reach20");
    sf_in = ~sf_exp;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done("sb");

    // Reset mid-pass, then a fresh pass with new scale factors.
    tick();
    fill_ram(1);
    start_pass(rand_sf());
    wait_rows(30, "mr_reach30");
    #2 rst = 1'b1;
    #1;
    chk("mr_busy", RW'(busy), RW'(0));
    chk("mr_valid", RW'(valid), RW'(0));
    chk("mr_re", RW'(ram_re), RW'(0));
    chk("mr_done", RW'(done), RW'(0));
    chk("mr_ram_addr", RW'(ram_addr), RW'(0));
    tick();
    rst = 1'b0;
    repeat (3) tick();
    chk("mr_idle_valid", RW'(valid), RW'(0));
    chk("mr_idle_busy", RW'(busy), RW'(0));
    fill_ram(1);
    start_pass(rand_sf());
    wait_done("mr_new");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
